i4004_timing_ctrl: RTL

I4004_TIMING_CTRL -- requirements
Module: i4004_timing_ctrl

---
 rtl/i4004_timing_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/i4004_timing_ctrl.sv
// Instruction-cycle timing for a 4004-style CPU: two-phase clock, the eight
// machine states A1..X3, SYNC, bus enable and CM-ROM/CM-RAM command strobes.
module i4004_timing_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk_i,
  input  logic       RESET_i,
  input  logic       src_i,
  input  logic       io_i,
  input  logic       ext_i,
  input  logic [1:0] bank_i,
  output logic       PHI1_o,
  output logic       PHI2_o,
  output logic       SYNC_o,
  output logic [2:0] state_o,
  output logic       state_stb_o,
  output logic       bus_oe_o,
  output logic       CM_ROM_o,
  output logic [3:0] CM_RAM_o,
  output logic       second_word_o
);

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} state_t;

  localparam logic [7:0] DIV_MAX = 8'(DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [1:0] q;
  logic       stb;
  logic       src_l;
  logic       io_l;
  logic       ext_l;
  logic [1:0] bank_l;
  logic       second_word;

  logic       last_tick;
  logic       adv;
  logic       m2_stb;
  logic       io_eff;
  logic [1:0] bank_eff;
  logic       src_act;

  assign last_tick = (div_cnt == DIV_MAX);
  assign adv       = last_tick && (q == 2'd3);
  assign m2_stb    = (state == M2) && stb;
  // On the M2 strobe clock the latch has not captured yet, so use the live inputs.
  assign io_eff    = m2_stb ? io_i : io_l;
  assign bank_eff  = m2_stb ? bank_i : bank_l;
  assign src_act   = src_l && !second_word;

  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      state       <= A1;
      div_cnt     <= 8'd0;
      q           <= 2'd0;
      stb         <= 1'b1;
      src_l       <= 1'b0;
      io_l        <= 1'b0;
      ext_l       <= 1'b0;
      bank_l      <= 2'd0;
      second_word <= 1'b0;
    end else begin
      div_cnt <= last_tick ? 8'd0 : div_cnt + 8'd1;
      if (last_tick) q <= q + 2'd1;
      stb <= adv;
      if (adv) begin
        state <= state_t'(3'(state + 3'd1));
        if (state == X3) second_word <= ext_l;
      end
      if (m2_stb) begin
        src_l  <= src_i;
        io_l   <= io_i;
        // A second word never starts another pair, so pairs always alternate.
        ext_l  <= ext_i && !second_word;
        bank_l <= bank_i;
      end
    end
  end

  always_comb begin
    PHI1_o      = 1'b0;
    PHI2_o      = 1'b0;
    SYNC_o      = 1'b1;
    state_stb_o = 1'b0;
    bus_oe_o    = 1'b0;
    CM_ROM_o    = 1'b0;
    CM_RAM_o    = 4'd0;
    if (!RESET_i) begin
      PHI1_o      = (q == 2'd0);
      PHI2_o      = (q == 2'd2);
      SYNC_o      = (state != X3);
      state_stb_o = stb;
      case (state)
        A1, A2, A3: bus_oe_o = 1'b1;
        M2: begin
          CM_ROM_o = 1'b1;
          if (io_eff && !second_word) CM_RAM_o = 4'b0001 << bank_eff;
        end
        X2: begin
          if (src_act) begin
            bus_oe_o = 1'b1;
            CM_ROM_o = 1'b1;
            CM_RAM_o = 4'b0001 << bank_l;
          end
        end
        X3: bus_oe_o = src_act;
        default: ;
      endcase
    end
  end

  assign state_o       = state;
  assign second_word_o = second_word;

endmodule
